id_stage: RTL and testbench

Instruction-decode stage of the pipelined processor, directly upstream of `reg_file` and feeding the EX stage. It holds the IF/ID pipeline register, drives the register-file read ports `PR1`/`PR2`, and decodes the instruction into control bits and an extended immediate. It detects load-use hazards (stalling IF and inserting a bubble) and captures everything, including `RD1`/`RD2`, into the ID/EX pipeline register.

---
 rtl/id_stage.sv | 213 +++++++++++++++++++++
 tb/tb_id_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage.
// Holds the IF/ID pipeline register, drives the register-file read addresses, decodes the
// instruction into control bits and an extended immediate, detects load-use hazards and
// captures the decoded instruction plus register operands into the ID/EX pipeline register.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               branch taken in EX: kills IF/ID and ID/EX contents
//   if_valid/instr/pc   fetched instruction from IF
//   stall               asks IF to hold its PC and output
//   PR1, PR2            register-file read addresses (rs, rt)
//   RD1, RD2            register-file read data
//   idex_*              ID/EX pipeline register contents
//   illegal_op          registered one-cycle pulse on an unknown opcode
module id_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            stall,
  output logic [4:0]      PR1,
  output logic [4:0]      PR2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [XLEN-1:0] idex_a,
  output logic [XLEN-1:0] idex_b,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rs,
  output logic [4:0]      idex_rt,
  output logic [4:0]      idex_dst,
  output logic [5:0]      idex_funct,
  output logic            idex_regwrite,
  output logic            idex_memread,
  output logic            idex_memwrite,
  output logic            idex_branch,
  output logic            idex_alusrc,
  output logic [1:0]      idex_aluop,
  output logic            illegal_op
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;

  // IF/ID register
  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;

  // ID/EX register
  logic            r_idex_valid;
  logic [XLEN-1:0] r_idex_pc, r_idex_a, r_idex_b, r_idex_imm;
  logic [4:0]      r_idex_rs, r_idex_rt, r_idex_dst;
  logic [5:0]      r_idex_funct;
  logic            r_idex_regwrite, r_idex_memread, r_idex_memwrite, r_idex_branch;
  logic            r_idex_alusrc;
  logic [1:0]      r_idex_aluop;
  logic            r_illegal;

  // Instruction fields
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm16;
  logic        w_unused;

  assign w_opcode = r_ifid_instr[31:26];
  assign w_rs     = r_ifid_instr[25:21];
  assign w_rt     = r_ifid_instr[20:16];
  assign w_rd     = r_ifid_instr[15:11];
  assign w_funct  = r_ifid_instr[5:0];
  assign w_imm16  = r_ifid_instr[15:0];
  assign w_unused = ^r_ifid_instr[10:6];

  // Decoded control
  logic            w_known, w_uses_rs, w_uses_rt, w_sext;
  logic            w_regwrite, w_memread, w_memwrite, w_branch, w_alusrc;
  logic [1:0]      w_aluop;
  logic [4:0]      w_dst;
  logic [XLEN-1:0] w_imm;

  always_comb begin
    w_known    = 1'b1;
    w_uses_rs  = 1'b0;
    w_uses_rt  = 1'b0;
    w_sext     = 1'b1;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_alusrc   = 1'b0;
    w_aluop    = 2'b00;
    w_dst      = 5'd0;
    unique case (w_opcode)
      OpRtype: begin
        w_regwrite = 1'b1; w_dst = w_rd; w_aluop = 2'b10;
        w_uses_rs = 1'b1; w_uses_rt = 1'b1;
      end
      OpAddi: begin
        w_regwrite = 1'b1; w_dst = w_rt; w_alusrc = 1'b1; w_uses_rs = 1'b1;
      end
      OpAndi: begin
        w_regwrite = 1'b1; w_dst = w_rt; w_aluop = 2'b11; w_alusrc = 1'b1;
        w_sext = 1'b0; w_uses_rs = 1'b1;
      end
      OpLw: begin
        w_regwrite = 1'b1; w_memread = 1'b1; w_dst = w_rt; w_alusrc = 1'b1;
        w_uses_rs = 1'b1;
      end
      OpSw: begin
        w_memwrite = 1'b1; w_alusrc = 1'b1; w_uses_rs = 1'b1; w_uses_rt = 1'b1;
      end
      OpBeq: begin
        w_branch = 1'b1; w_aluop = 2'b01; w_uses_rs = 1'b1; w_uses_rt = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
    // Writes to register 0 are discarded at the source
    if (w_dst == 5'd0) w_regwrite = 1'b0;
  end

  assign w_imm = w_sext ? {{(XLEN-16){w_imm16[15]}}, w_imm16} : {{(XLEN-16){1'b0}}, w_imm16};

  // Load-use hazard: the load in ID/EX produces a register this instruction reads
  logic w_hazard, w_stall, w_issue;
  assign w_hazard = r_ifid_valid & r_idex_valid & r_idex_memread & (r_idex_dst != 5'd0) &
                    ((w_uses_rs & (w_rs == r_idex_dst)) | (w_uses_rt & (w_rt == r_idex_dst)));
  assign w_stall  = w_hazard & ~flush;
  assign w_issue  = r_ifid_valid & w_known & ~w_stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else begin
      if (!w_stall) begin
        r_ifid_instr <= if_instr;
        r_ifid_pc    <= if_pc;
      end
      if (flush)         r_ifid_valid <= 1'b0;
      else if (!w_stall) r_ifid_valid <= if_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex_valid    <= 1'b0;
      r_idex_pc       <= '0;
      r_idex_a        <= '0;
      r_idex_b        <= '0;
      r_idex_imm      <= '0;
      r_idex_rs       <= '0;
      r_idex_rt       <= '0;
      r_idex_dst      <= '0;
      r_idex_funct    <= '0;
      r_idex_regwrite <= 1'b0;
      r_idex_memread  <= 1'b0;
      r_idex_memwrite <= 1'b0;
      r_idex_branch   <= 1'b0;
      r_idex_alusrc   <= 1'b0;
      r_idex_aluop    <= 2'b00;
      r_illegal       <= 1'b0;
    end else begin
      // Bubbles clear only valid and control; data fields are don't-care
      r_idex_valid    <= w_issue;
      r_idex_regwrite <= w_issue & w_regwrite;
      r_idex_memread  <= w_issue & w_memread;
      r_idex_memwrite <= w_issue & w_memwrite;
      r_idex_branch   <= w_issue & w_branch;
      r_idex_alusrc   <= w_issue & w_alusrc;
      r_idex_aluop    <= w_issue ? w_aluop : 2'b00;
      r_idex_pc       <= r_ifid_pc;
      r_idex_a        <= (w_rs == 5'd0) ? '0 : RD1;
      r_idex_b        <= (w_rt == 5'd0) ? '0 : RD2;
      r_idex_imm      <= w_imm;
      r_idex_rs       <= w_rs;
      r_idex_rt       <= w_rt;
      r_idex_dst      <= w_dst;
      r_idex_funct    <= w_funct;
      r_illegal       <= r_ifid_valid & ~w_known;
    end
  end

  assign stall         = w_stall;
  assign PR1           = w_rs;
  assign PR2           = w_rt;
  assign idex_valid    = r_idex_valid;
  assign idex_pc       = r_idex_pc;
  assign idex_a        = r_idex_a;
  assign idex_b        = r_idex_b;
  assign idex_imm      = r_idex_imm;
  assign idex_rs       = r_idex_rs;
  assign idex_rt       = r_idex_rt;
  assign idex_dst      = r_idex_dst;
  assign idex_funct    = r_idex_funct;
  assign idex_regwrite = r_idex_regwrite;
  assign idex_memread  = r_idex_memread;
  assign idex_memwrite = r_idex_memwrite;
  assign idex_branch   = r_idex_branch;
  assign idex_alusrc   = r_idex_alusrc;
  assign idex_aluop    = r_idex_aluop;
  assign illegal_op    = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios with literal expectations plus randomized
// instruction streams compared every cycle against a behavioural pipeline model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        stall;
  logic [4:0]  PR1, PR2;
  logic [31:0] RD1, RD2;
  logic        idex_valid;
  logic [31:0] idex_pc, idex_a, idex_b, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_dst;
  logic [5:0]  idex_funct;
  logic        idex_regwrite, idex_memread, idex_memwrite, idex_branch, idex_alusrc;
  logic [1:0]  idex_aluop;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Register file contents seen by the read ports
  logic [31:0] rf [32];
  assign RD1 = rf[PR1];
  assign RD2 = rf[PR2];

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .stall(stall), .PR1(PR1), .PR2(PR2), .RD1(RD1), .RD2(RD2),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_a(idex_a), .idex_b(idex_b),
    .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_dst(idex_dst),
    .idex_funct(idex_funct), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_memwrite(idex_memwrite), .idex_branch(idex_branch), .idex_alusrc(idex_alusrc),
    .idex_aluop(idex_aluop), .illegal_op(illegal_op)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt, dst;
    logic [5:0]  funct;
    logic        rw, mr, mw, br, as;
    logic [1:0]  aluop;
  } ex_t;

  logic        m_v = 1'b0;
  logic [31:0] m_ins = '0;
  logic [31:0] m_pc = '0;
  ex_t         m_ex = '0;
  logic        m_ill = 1'b0;

  function automatic logic known_op(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h0C, 6'h23, 6'h2B, 6'h04};
  endfunction
  function automatic logic reads_rs(input logic [5:0] op);
    return known_op(op);
  endfunction
  function automatic logic reads_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h2B, 6'h04};
  endfunction

  // What the instruction means, straight from the opcode table
  function automatic ex_t meaning(input logic [31:0] ins, input logic [31:0] pc);
    ex_t e;
    e = '0;
    e.pc    = pc;
    e.rs    = ins[25:21];
    e.rt    = ins[20:16];
    e.funct = ins[5:0];
    e.a     = (e.rs == 0) ? 32'd0 : rf[e.rs];
    e.b     = (e.rt == 0) ? 32'd0 : rf[e.rt];
    e.imm   = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00: begin e.rw = 1; e.dst = ins[15:11]; e.aluop = 2'b10; end
      6'h08: begin e.rw = 1; e.dst = ins[20:16]; e.as = 1; end
      6'h0C: begin e.rw = 1; e.dst = ins[20:16]; e.as = 1; e.aluop = 2'b11;
                   e.imm = {16'h0, ins[15:0]}; end
      6'h23: begin e.rw = 1; e.mr = 1; e.dst = ins[20:16]; e.as = 1; end
      6'h2B: begin e.mw = 1; e.as = 1; end
      6'h04: begin e.br = 1; e.aluop = 2'b01; end
      default: ;
    endcase
    if (e.dst == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic m_stall();
    logic [5:0] op;
    op = m_ins[31:26];
    return m_v && m_ex.valid && m_ex.mr && (m_ex.dst != 0) &&
           ((reads_rs(op) && m_ins[25:21] == m_ex.dst) ||
            (reads_rt(op) && m_ins[20:16] == m_ex.dst)) && !flush;
  endfunction

  function automatic ex_t m_next_ex();
    ex_t e;
    if (m_v && known_op(m_ins[31:26]) && !flush && !m_stall()) begin
      e = meaning(m_ins, m_pc);
      e.valid = 1'b1;
    end else begin
      e = '0;
    end
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_v <= 1'b0; m_ins <= '0; m_pc <= '0; m_ex <= '0; m_ill <= 1'b0;
    end else begin
      m_ex  <= m_next_ex();
      m_ill <= m_v && !known_op(m_ins[31:26]);
      if (!m_stall()) begin
        m_ins <= if_instr;
        m_pc  <= if_pc;
      end
      m_v <= flush ? 1'b0 : (m_stall() ? m_v : if_valid);
    end
  end

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    check("stall", stall, m_stall());
    check("PR1", PR1, m_ins[25:21]);
    check("PR2", PR2, m_ins[20:16]);
    check("valid", idex_valid, m_ex.valid);
    check("regwrite", idex_regwrite, m_ex.rw);
    check("memread", idex_memread, m_ex.mr);
    check("memwrite", idex_memwrite, m_ex.mw);
    check("branch", idex_branch, m_ex.br);
    check("alusrc", idex_alusrc, m_ex.as);
    check("aluop", idex_aluop, m_ex.aluop);
    check("illegal", illegal_op, m_ill);
    if (m_ex.valid) begin
      check("pc", idex_pc, m_ex.pc);
      check("a", idex_a, m_ex.a);
      check("b", idex_b, m_ex.b);
      check("rs", idex_rs, m_ex.rs);
      check("rt", idex_rt, m_ex.rt);
      check("funct", idex_funct, m_ex.funct);
      if (!m_ex.mw && !m_ex.br) check("dst", idex_dst, m_ex.dst);
      if (m_ex.as || m_ex.br) check("imm", idex_imm, m_ex.imm);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc_ctr = 32'h1000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] ins);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc_ctr;
    pc_ctr   = pc_ctr + 4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [15:0] lo;
    case ($urandom_range(0, 7))
      0: op = 6'h00; 1: op = 6'h08; 2: op = 6'h0C; 3: op = 6'h23;
      4: op = 6'h2B; 5: op = 6'h04; 6: op = 6'h3F; default: op = 6'h02;
    endcase
    lo = 16'($urandom);
    lo[15:11] = 5'($urandom_range(0, 3));
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), lo};
  endfunction

  localparam logic [31:0] LwR4  = 32'h8C24_0000; // lw  r4,0(r1)
  localparam logic [31:0] AddHz = 32'h0082_2820; // add r5,r4,r2

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = i;
    rf[0] = 32'd7;

    // Reset state
    #8;
    check("rst_stall", stall, 0);
    check("rst_PR1", PR1, 0);
    check("rst_PR2", PR2, 0);
    check("rst_valid", idex_valid, 0);
    check("rst_pc", idex_pc, 0);
    check("rst_a", idex_a, 0);
    check("rst_imm", idex_imm, 0);
    check("rst_regwrite", idex_regwrite, 0);
    check("rst_illegal", illegal_op, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADDI r3,r6,-2
    drv(1, 32'h20C3_FFFE);
    tick();
    check("addi_PR1", PR1, 6);
    check("addi_PR2", PR2, 3);
    drv(0, 0);
    tick();
    check("addi_valid", idex_valid, 1);
    check("addi_a", idex_a, 6);
    check("addi_imm", idex_imm, 32'hFFFF_FFFE);
    check("model_imm", m_ex.imm, 32'hFFFF_FFFE);
    check("addi_dst", idex_dst, 3);
    check("addi_rw", idex_regwrite, 1);
    check("addi_alusrc", idex_alusrc, 1);

    // Load-use: exactly one stall cycle and one bubble
    drv(1, LwR4);
    tick();
    drv(1, AddHz);
    tick();
    check("lu_stall", stall, 1);
    check("lu_memread", idex_memread, 1);
    tick();
    check("lu_bubble", idex_valid, 0);
    check("lu_stall_end", stall, 0);
    check("lu_held_PR1", PR1, 4);
    drv(0, 0);
    tick();
    check("lu_add_valid", idex_valid, 1);
    check("lu_add_rs", idex_rs, 4);
    check("lu_add_dst", idex_dst, 5);

    // No hazard cases; register 0 reads as zero
    drv(1, LwR4);
    tick();
    drv(1, 32'h0002_2820); // add r5,r0,r2
    tick();
    check("nh_stall1", stall, 0);
    drv(1, 32'h8C20_0000); // lw r0,0(r1)
    tick();
    check("nh_stall2", stall, 0);
    check("nh_a_zero", idex_a, 0);
    check("nh_b", idex_b, 2);
    drv(1, 32'h0000_2820); // add r5,r0,r0
    tick();
    check("nh_stall3", stall, 0);
    drv(0, 0);
    tick();
    check("nh_a_zero2", idex_a, 0);
    check("nh_b_zero2", idex_b, 0);

    // Flush wins over stall
    drv(1, LwR4);
    tick();
    drv(1, AddHz);
    tick();
    flush = 1'b1;
    #1;
    check("fl_stall", stall, 0);
    tick();
    check("fl_idex_valid", idex_valid, 0);
    flush = 1'b0;
    drv(0, 0);
    tick();
    check("fl_ifid_cleared", idex_valid, 0);

    // Immediate extension
    drv(1, 32'h3022_8001); // andi r2,r1,0x8001
    tick();
    drv(1, 32'hAC22_8001); // sw r2,0x8001(r1)
    tick();
    check("andi_imm", idex_imm, 32'h0000_8001);
    check("andi_aluop", idex_aluop, 2'b11);
    drv(0, 0);
    tick();
    check("sw_imm", idex_imm, 32'hFFFF_8001);
    check("sw_memwrite", idex_memwrite, 1);
    check("sw_regwrite", idex_regwrite, 0);

    // Illegal opcode
    drv(1, 32'hFC00_0000);
    tick();
    drv(0, 0);
    tick();
    check("ill_pulse", illegal_op, 1);
    check("ill_valid", idex_valid, 0);
    tick();
    check("ill_pulse_end", illegal_op, 0);

    // Reset during a stall
    drv(1, LwR4);
    tick();
    drv(1, AddHz);
    tick();
    check("rs_stall", stall, 1);
    reset = 1'b1;
    #1;
    check("rs_stall_drop", stall, 0);
    check("rs_valid_drop", idex_valid, 0);
    tick();
    reset = 1'b0;
    drv(0, 0);
    tick();
    check("rs_ifid_cleared", idex_valid, 0);

    // Randomized stream
    for (int i = 0; i < 3000; i++) begin
      drv(1'($urandom_range(0, 3) != 0), rand_instr());
      flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;
    drv(0, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
